// File: rtl/mem_port_arbiter.sv
// Shared memory-port arbiter/sequencer for IF and LS: grants one transaction, counts MEM_LAT, returns data.
// Optional MEM_ARB_RR_EN selects round-robin arbitration instead of fixed LS-over-IF priority.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          sel,
  output logic          busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          store_q, store_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic          ls_rvalid_q, ls_rvalid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] ls_rdata_q, ls_rdata_d;

  logic arb_open;
  logic grant;
  logic win_ls;

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;

  // On contention the requester not granted last wins; a lone requester always wins.
  assign win_ls = ls_req && (!if_req || !last_q);

  always_comb begin
    last_d = last_q;
    if (grant) last_d = win_ls;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`else
  assign win_ls = ls_req;
`endif

  // rst_n gates the grant so no strobe leaks out while reset is held with a request pending.
  assign arb_open = rst_n && (state_q != ST_WAIT);
  assign grant    = arb_open && (if_req || ls_req);

  always_comb begin
    if_gnt    = grant && !win_ls;
    ls_gnt    = grant && win_ls;
    mem_en    = grant;
    mem_we    = grant && win_ls && ls_we;
    sel       = grant ? win_ls : owner_q;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant) begin
      mem_addr  = win_ls ? ls_addr : if_addr;
      mem_wdata = win_ls ? ls_wdata : '0;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign if_rvalid = if_rvalid_q;
  assign ls_rvalid = ls_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    store_d     = store_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (grant) begin
          state_d = ST_WAIT;
          cnt_d   = 4'(MEM_LAT - 1);
          owner_d = win_ls;
          store_d = win_ls && ls_we;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          if (owner_q) begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = store_q ? '0 : mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      store_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      store_q     <= store_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance A uses MEM_LAT=1, instance B uses MEM_LAT=3.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif
  localparam bit FIRST_LS = !RR_BUILD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // ---------------- instance A (MEM_LAT=1)
  logic        a_rst_n, a_if_req, a_ls_req, a_ls_we;
  logic [31:0] a_if_addr, a_ls_addr, a_ls_wdata, a_mem_rdata;
  logic        a_if_gnt, a_if_rvalid, a_ls_gnt, a_ls_rvalid;
  logic        a_mem_en, a_mem_we, a_sel, a_busy;
  logic [31:0] a_if_rdata, a_ls_rdata, a_mem_addr, a_mem_wdata;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut_a (
    .clk(clk), .rst_n(a_rst_n),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .ls_req(a_ls_req), .ls_we(a_ls_we), .ls_addr(a_ls_addr), .ls_wdata(a_ls_wdata),
    .ls_gnt(a_ls_gnt), .ls_rvalid(a_ls_rvalid), .ls_rdata(a_ls_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
    .sel(a_sel), .busy(a_busy)
  );

  // ---------------- instance B (MEM_LAT=3)
  logic        b_rst_n, b_if_req, b_ls_req, b_ls_we;
  logic [31:0] b_if_addr, b_ls_addr, b_ls_wdata, b_mem_rdata;
  logic        b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid;
  logic        b_mem_en, b_mem_we, b_sel, b_busy;
  logic [31:0] b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata),
    .ls_gnt(b_ls_gnt), .ls_rvalid(b_ls_rvalid), .ls_rdata(b_ls_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .sel(b_sel), .busy(b_busy)
  );

  // Memory models: read data appears only in the cycle exactly MEM_LAT after mem_en.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], 16'hC0DE};
  endfunction

  logic        a_p_v = 1'b0;
  logic [31:0] a_p_a = '0;
  always @(posedge clk) begin
    a_p_v <= a_mem_en && !a_mem_we;
    a_p_a <= a_mem_addr;
  end
  assign a_mem_rdata = a_p_v ? mem_val(a_p_a) : 32'hBAD0BAD0;

  logic [2:0]  b_p_v = '0;
  logic [31:0] b_p_a0 = '0, b_p_a1 = '0, b_p_a2 = '0;
  always @(posedge clk) begin
    b_p_v  <= {b_p_v[1:0], b_mem_en && !b_mem_we};
    b_p_a0 <= b_mem_addr;
    b_p_a1 <= b_p_a0;
    b_p_a2 <= b_p_a1;
  end
  assign b_mem_rdata = b_p_v[2] ? mem_val(b_p_a2) : 32'hBAD0BAD0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt_a(output logic who, output int unsigned n);
    n = 0;
    while (!(a_if_gnt || a_ls_gnt) && n < 10) begin
      step();
      n++;
    end
    who = a_ls_gnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic        who;
    int unsigned waited;

    a_rst_n = 1'b0; a_if_req = 1'b1; a_if_addr = 32'h100;
    a_ls_req = 1'b0; a_ls_we = 1'b0; a_ls_addr = '0; a_ls_wdata = '0;
    b_rst_n = 1'b0; b_if_req = 1'b0; b_if_addr = '0;
    b_ls_req = 1'b0; b_ls_we = 1'b0; b_ls_addr = '0; b_ls_wdata = '0;
    step(); step();

    // Reset with IF request held
    check("rst_strobes", {24'h0, a_if_gnt, a_ls_gnt, a_mem_en, a_mem_we,
                          a_if_rvalid, a_ls_rvalid, a_busy, a_sel}, 32'h0);
    check("rst_mem_addr", a_mem_addr, 32'h0);
    check("rst_mem_wdata", a_mem_wdata, 32'h0);
    check("rst_if_rdata", a_if_rdata, 32'h0);
    check("rst_ls_rdata", a_ls_rdata, 32'h0);

    a_rst_n = 1'b1; #1;
    check("t1_if_gnt", a_if_gnt, 1);
    check("t1_mem_en", a_mem_en, 1);
    check("t1_mem_addr", a_mem_addr, 32'h100);
    check("t1_sel", a_sel, 0);
    check("t1_mem_we", a_mem_we, 0);
    step(); a_if_req = 1'b0; #1;
    check("t1_wait_busy", a_busy, 1);
    check("t1_wait_gnt", {30'h0, a_if_gnt, a_mem_en}, 32'h0);
    check("t1_wait_rvalid", a_if_rvalid, 0);
    step();
    check("t1_rvalid", a_if_rvalid, 1);
    check("t1_rdata", a_if_rdata, 32'hDEADBEEF);
    step();
    check("t1_rvalid_pulse", a_if_rvalid, 0);
    check("t1_idle_busy", a_busy, 0);
    check("t1_rdata_hold", a_if_rdata, 32'hDEADBEEF);

    // LS store
    a_ls_req = 1'b1; a_ls_we = 1'b1; a_ls_addr = 32'h200; a_ls_wdata = 32'h12345678; #1;
    check("t2_ls_gnt", a_ls_gnt, 1);
    check("t2_if_gnt", a_if_gnt, 0);
    check("t2_mem_we", a_mem_we, 1);
    check("t2_sel", a_sel, 1);
    check("t2_mem_addr", a_mem_addr, 32'h200);
    check("t2_mem_wdata", a_mem_wdata, 32'h12345678);
    step(); a_ls_req = 1'b0; a_ls_we = 1'b0; #1;
    check("t2_wait_sel", a_sel, 1);
    check("t2_wait_rvalid", a_ls_rvalid, 0);
    step();
    check("t2_ls_rvalid", a_ls_rvalid, 1);
    check("t2_ls_rdata", a_ls_rdata, 32'h0);
    check("t2_if_rvalid", a_if_rvalid, 0);
    step();
    check("t2_rvalid_pulse", a_ls_rvalid, 0);
    check("t2_idle_sel_hold", a_sel, 1);
    check("t2_if_rdata_hold", a_if_rdata, 32'hDEADBEEF);

    // Contention, winner drops its request after grant
    a_if_req = 1'b1; a_if_addr = 32'h300;
    a_ls_req = 1'b1; a_ls_we = 1'b0; a_ls_addr = 32'h400; #1;
    check("t3_first_winner", a_ls_gnt, FIRST_LS);
    check("t3_one_gnt", a_if_gnt ^ a_ls_gnt, 1);
    check("t3_first_addr", a_mem_addr, FIRST_LS ? 32'h400 : 32'h300);
    step(); a_ls_req = !FIRST_LS; a_if_req = FIRST_LS; #1;
    check("t3_wait_no_gnt", {30'h0, a_if_gnt, a_ls_gnt}, 32'h0);
    step();
    check("t3_first_rvalid", FIRST_LS ? a_ls_rvalid : a_if_rvalid, 1);
    check("t3_first_rdata", FIRST_LS ? a_ls_rdata : a_if_rdata,
          FIRST_LS ? 32'h0400C0DE : 32'h0300C0DE);
    check("t3_second_winner", a_ls_gnt, !FIRST_LS);
    check("t3_second_gnt", a_if_gnt ^ a_ls_gnt, 1);
    check("t3_second_sel", a_sel, !FIRST_LS);
    check("t3_second_addr", a_mem_addr, FIRST_LS ? 32'h300 : 32'h400);
    step(); a_ls_req = 1'b0; a_if_req = 1'b0; #1;
    step();
    check("t3_second_rvalid", FIRST_LS ? a_if_rvalid : a_ls_rvalid, 1);
    check("t3_second_rdata", FIRST_LS ? a_if_rdata : a_ls_rdata,
          FIRST_LS ? 32'h0300C0DE : 32'h0400C0DE);
    step();

    // Continuous contention over 6 transactions
    a_if_req = 1'b1; a_ls_req = 1'b1; #1;
    for (int k = 0; k < 6; k++) begin
      wait_gnt_a(who, waited);
      check("t3b_gnt_seen", {31'h0, a_if_gnt || a_ls_gnt}, 32'h1);
      check("t3b_winner", who, RR_BUILD ? (k % 2 == 1) : 1'b1);
      check("t3b_gap", waited, (k == 0) ? 32'd0 : 32'd1);
      check("t3b_addr", a_mem_addr, who ? 32'h400 : 32'h300);
      step();
    end
    a_if_req = 1'b0; a_ls_req = 1'b0; #1;
    step(); step(); step();
    check("t3b_drained", a_busy, 0);

    // Reset one cycle after an LS load grant
    a_ls_req = 1'b1; a_ls_we = 1'b0; a_ls_addr = 32'h600; #1;
    check("t5_ls_gnt", a_ls_gnt, 1);
    step(); a_ls_req = 1'b0; a_rst_n = 1'b0; #1;
    check("t5_rst_busy", a_busy, 0);
    check("t5_rst_outs", {28'h0, a_ls_rvalid, a_sel, a_mem_en, a_ls_gnt}, 32'h0);
    check("t5_rst_ls_rdata", a_ls_rdata, 32'h0);
    step();
    check("t5_rst_rvalid", a_ls_rvalid, 0);
    a_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("t5_no_rvalid", {30'h0, a_ls_rvalid, a_busy}, 32'h0);
    end
    a_if_req = 1'b1; a_if_addr = 32'h700; #1;
    check("t5_new_gnt", a_if_gnt, 1);
    check("t5_new_addr", a_mem_addr, 32'h700);
    step(); a_if_req = 1'b0; #1;
    step();
    check("t5_new_rvalid", a_if_rvalid, 1);
    check("t5_new_rdata", a_if_rdata, 32'h0700C0DE);
    step();

    // MEM_LAT=3, continuous IF requests
    b_rst_n = 1'b1; b_if_req = 1'b1; b_if_addr = 32'h500; #1;
    for (int c = 0; c < 13; c++) begin
      check("t4_if_gnt", b_if_gnt, (c % 4 == 0));
      check("t4_mem_en", b_mem_en, (c % 4 == 0));
      check("t4_busy", b_busy, (c != 0));
      check("t4_rvalid", b_if_rvalid, (c % 4 == 0) && (c >= 4));
      step();
    end
    b_if_req = 1'b0; #1;
    check("t4_rdata", b_if_rdata, 32'h0500C0DE);
    for (int c = 0; c < 5; c++) step();
    check("t4_drained", b_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single shared memory port of the multi-cycle MIPS core. It accepts requests from instruction fetch (IF) and load/store (LS) and grants one transaction at a time. For the granted requester it drives the port's address/data select and counts the fixed memory latency. It then returns read data, or a write acknowledge, with a one-cycle valid pulse.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `MEM_LAT`, 1, cycles from `mem_en` to valid `mem_rdata`; legal range 1..15

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `if_req`  in  1  IF read request, held until `if_gnt`
- `if_addr`  in  AW  IF address, stable while `if_req` is high
- `if_gnt`  out  1  IF request accepted (combinational, one cycle)
- `if_rvalid`  out  1  IF read data valid (registered pulse)
- `if_rdata`  out  DW  IF read data
- `ls_req`  in  1  LS request, held until `ls_gnt`
- `ls_we`  in  1  LS write enable (1 = store)
- `ls_addr`  in  AW  LS address
- `ls_wdata`  in  DW  LS store data
- `ls_gnt`  out  1  LS request accepted
- `ls_rvalid`  out  1  LS load data valid, or store acknowledge
- `ls_rdata`  out  DW  LS load data (0 on store acknowledge)
- `mem_en`  out  1  memory access strobe, one cycle per transaction
- `mem_we`  out  1  memory write
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid `MEM_LAT` cycles after `mem_en`
- `sel`  out  1  port mux select: 0 = IF, 1 = LS
- `busy`  out  1  transaction in flight (state ≠ IDLE)

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE, with no request:
  - all strobes are 0; `sel` holds the last owner.
- IDLE, with any request:
  - the arbiter picks a winner;
  - `*_gnt` and `mem_en` are asserted combinationally in that same cycle;
  - `sel` is driven to the winner;
  - `mem_addr` and `mem_wdata` come from the winner through the port mux;
  - `mem_we` = `ls_we` for an LS win, 0 for an IF win;
  - owner register ← winner; latency counter ← `MEM_LAT`-1; next state WAIT.
- WAIT:
  - counter decrements each cycle;
  - when counter = 0, `mem_rdata` is registered into the owner's rdata;
  - next state RESP.
- RESP:
  - the owner's `*_rvalid` = 1 for exactly one cycle;
  - for a store, `ls_rdata` = 0;
  - the arbiter may grant a new request in this same cycle (RESP behaves as IDLE for arbitration), so back-to-back issue is possible;
  - next state is WAIT if a request is granted, else IDLE.
- `sel` is held at the owner value during WAIT and RESP, except in a RESP cycle that grants, where it takes the new winner.
- Arbitration (default): fixed priority, LS over IF, so data accesses unblock the pipeline first.
- The non-granted requester keeps `req` high and is serviced later; it receives no `gnt` in the meantime.
- A single requester alone is granted immediately.
- Only one transaction is outstanding at any time; `gnt` never asserts in WAIT.

## Timing
- Reset values: `if_gnt`, `ls_gnt`, `mem_en`, `mem_we`, `if_rvalid`, `ls_rvalid`, `busy`, `sel` = 0; `mem_addr`, `mem_wdata`, `if_rdata`, `ls_rdata` = 0; state IDLE; owner = IF.
- Grant at cycle T:
  - `mem_en` at T;
  - `mem_rdata` sampled at T+`MEM_LAT`;
  - `*_rvalid` at T+`MEM_LAT`+1.
- Throughput: one transaction per `MEM_LAT`+1 cycles with continuous requests.
- Reset asserted mid-transaction: the transaction is aborted, no `rvalid` is issued, and all outputs return to reset values asynchronously.
- A requester that drops `req` before `gnt` withdraws cleanly; no state is kept for it.
- `rdata` holds its value until the next capture for the same requester.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - When both request, the winner is the one not granted last.
  - The last-granted register resets to LS, so IF wins the first contention.
  - A single requester is granted regardless of the pointer.
- `MEM_ARB_RR_EN` undefined: fixed LS-over-IF priority; the last-granted register is not built.

## Test plan
- Reset with `if_req`=1, `if_addr`=0x100 held, `MEM_LAT`=1:
  - all outputs 0 during reset;
  - after release: `if_gnt`, `mem_en`, `mem_addr`=0x100, `sel`=0 in the same cycle;
  - `mem_rdata`=0xDEADBEEF → `if_rvalid`=1, `if_rdata`=0xDEADBEEF two cycles after grant.
- LS store, `ls_addr`=0x200, `ls_wdata`=0x12345678:
  - `mem_we`=1, `sel`=1, `mem_wdata`=0x12345678;
  - `ls_rvalid` pulses with `ls_rdata`=0; `if_rvalid` stays 0.
- Simultaneous IF and LS requests, held, default build:
  - LS granted first and IF at the following RESP cycle;
  - with `MEM_ARB_RR_EN`: IF first, then LS, then alternating over 6 transactions.
- `MEM_LAT`=3, continuous IF requests:
  - `mem_en` every 4 cycles;
  - `busy` stays 1;
  - `if_gnt` never asserts while in WAIT.
- `rst_n` dropped one cycle after an LS load grant:
  - `ls_rvalid` never asserts;
  - state IDLE;
  - a new request after release is granted normally.
